adi_dma_split_logic: RTL and testbench
======================================

// Module: adi_dma_split_logic
// PURPOSE
//  AXI-Stream splitter; the inverse of the DMA packet combiner. Accepts one long input frame and
//  re-emits it as num_pkts packets of pkt_len beats each, inserting M_AXIS_TLAST on every packet
//  boundary. Sits between the TX DMA and a packet-oriented sink. Same cmd/status register
//  interface as the combiner.
// PARAMETERS
//  DATA_WIDTH  64  tdata width in bits
//  CNT_WIDTH   32  width of num_pkts, pkt_len and the internal counters
// PORTS
//  AXIS_ACLK      in   1           single clock; all logic is on the rising edge
//  AXIS_ARESET    in   1           synchronous, active-high reset
//  S_AXIS_TREADY  out  1           input ready
//  S_AXIS_TDATA   in   DATA_WIDTH  input data
//  S_AXIS_TLAST   in   1           end of input frame
//  S_AXIS_TVALID  in   1           input valid
//  M_AXIS_TVALID  out  1           output valid
//  M_AXIS_TDATA   out  DATA_WIDTH  output data
//  M_AXIS_TLAST   out  1           end of output packet
//  M_AXIS_TREADY  in   1           output ready
//  cmd            in   32          [0] en, [1] soft reset, [2] passthrough, [31:3] ignored
//  status         out  32          [0] done, [1] err_short, [2] err_long, [3] err_cfg,
//                                  [31:16] packets sent (saturating), all other bits 0
//  num_pkts       in   CNT_WIDTH   number of output packets per frame
//  pkt_len        in   CNT_WIDTH   beats per output packet
// BEHAVIOUR
//  - Reset: AXIS_ARESET or cmd[1] clears state to IDLE and zeroes counters, status and skid
//    buffer contents. S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
//    Soft reset mid-packet discards the buffered beats; no TLAST is generated for them.
//  - Transfer rules: xfr = VALID & READY. M_AXIS_TVALID never depends combinationally on
//    M_AXIS_TREADY. Once asserted, VALID/DATA/LAST hold until transferred.
//  - Latency: 1 cycle from S to M. Throughput is 1 beat/cycle via the 2-entry skid buffer.
//  - State machine:
//    IDLE:  TREADY=0. Moves to RUN when cmd[0]=1. On that edge, num_pkts and pkt_len are
//           latched and beat_cnt, pkt_cnt and the errors clear. If either value is 0, set
//           err_cfg and go to DONE.
//    RUN:   Beats forward. M TLAST = (beat_cnt==pkt_len-1) | (input TLAST).
//           On each M xfr: beat_cnt increments. At the packet end, beat_cnt resets to 0 and
//           pkt_cnt increments.
//           Last beat of the last packet with input TLAST=1 -> DONE.
//           Last beat of the last packet with input TLAST=0 -> set err_long, go to DRAIN.
//           Input TLAST before the last beat of the last packet -> forward it with TLAST=1,
//           set err_short, go to DONE.
//    DRAIN: S_AXIS_TREADY=1, M_AXIS_TVALID=0. Excess beats are discarded until an input TLAST
//           xfr, then go to DONE.
//    DONE:  TREADY=0, TVALID=0, status[0]=1. Held until cmd[0]=0, then return to IDLE.
//  - cmd[0] dropping mid-RUN: the current beat completes, then the block stalls (TREADY=0).
//    State and counters are kept, and the block resumes when cmd[0] returns to 1.
//  - Passthrough (cmd[2]=1): overrides everything except reset. S->M goes via the skid buffer
//    with TLAST copied from the input. Counters and state freeze. Passthrough changes only
//    take effect while the skid buffer is empty.
//  - Counter compares use CNT_WIDTH unsigned arithmetic. pkt_len=1 gives TLAST on every beat.
//    The packet count in status[31:16] saturates at 16'hFFFF.
//  - Counter and length compares must be registered; no combinational path from num_pkts or
//    pkt_len to M_AXIS_TLAST.
// STRUCTURE
//  - Shared package adi_dma_pkg: state encoding localparams (IDLE/RUN/DRAIN/DONE), cmd bit
//    indices (CMD_EN=0, CMD_RST=1, CMD_PASS=2), and status bit indices, shared with the
//    combiner.
//  - Sub-module adi_axis_skid_buf (DATA_WIDTH+1 payload, 2 entries) holds the register slice.
//    The top level contains only the FSM, the counters and TLAST generation.
// TESTING
//  1. num_pkts=3, pkt_len=4, 12-beat frame with TLAST on beat 12, M_TREADY=1
//     -> TLAST on beats 4, 8, 12; status=0x0003_0001.
//  2. Same config, random M_TREADY (50%) -> data order and values unchanged, TVALID/TDATA
//     stable under stall, same TLAST positions.
//  3. 10-beat frame (TLAST on beat 10)
//     -> TLAST on beats 4, 8, 10; status[1]=1; status[0]=1.
//  4. 15-beat frame -> 12 beats out, 3 beats discarded, status[2]=1, then DONE.
//  5. pkt_len=0 with en=1 -> DONE on the next cycle, status[3]=1, no input beats accepted.
//  6. Soft reset at beat 6 of case 1, then re-enable and rerun case 1 -> case 1 result
//     reproduced exactly. Passthrough with a 5-beat frame -> one TLAST, on beat 5.

Source files
------------

// File: rtl/adi_dma_pkg.sv
// -----------------------------------------------------------------------------
// adi_dma_pkg
// Shared definitions for the DMA packet combiner / splitter pair:
//   - FSM state encoding (IDLE/RUN/DRAIN/DONE)
//   - cmd register bit indices
//   - status register bit indices
//   - saturating 16-bit increment used for the packet counter in status
// -----------------------------------------------------------------------------
package adi_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  localparam int CMD_EN   = 0;
  localparam int CMD_RST  = 1;
  localparam int CMD_PASS = 2;

  localparam int STAT_DONE      = 0;
  localparam int STAT_ERR_SHORT = 1;
  localparam int STAT_ERR_LONG  = 2;
  localparam int STAT_ERR_CFG   = 3;
  localparam int STAT_CNT_LSB   = 16;
  localparam int STAT_CNT_MSB   = 31;

  // Packet counter in status sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adi_axis_skid_buf.sv
// -----------------------------------------------------------------------------
// adi_axis_skid_buf
// Two-entry AXI-Stream register slice. The output register drives the master
// side directly; the skid register catches the one beat accepted while the
// output is stalled, so s_ready is a pure register and throughput is 1/cycle.
// Ports:
//   clk, srst         clock, synchronous active-high reset (clears contents)
//   s_valid/s_ready/s_data   upstream handshake and payload
//   m_valid/m_ready/m_data   downstream handshake and payload
//   empty             both entries free
// -----------------------------------------------------------------------------
module adi_axis_skid_buf #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             empty
);

  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             out_valid_r;
  logic             skid_valid_r;
  logic             s_xfr_s;
  logic             out_free_s;

  assign s_ready    = ~skid_valid_r;
  assign s_xfr_s    = s_valid & ~skid_valid_r;
  assign out_free_s = ~out_valid_r | m_ready;
  assign m_valid    = out_valid_r;
  assign m_data     = out_data_r;
  assign empty      = ~out_valid_r & ~skid_valid_r;

  // Output/skid register update; skid always empties first to keep order.
  always_ff @(posedge clk) begin
    if (srst) begin
      out_data_r   <= {WIDTH{1'b0}};
      skid_data_r  <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        out_valid_r <= s_xfr_s;
        if (s_xfr_s) begin
          out_data_r <= s_data;
        end
      end
    end else if (s_xfr_s) begin
      skid_data_r  <= s_data;
      skid_valid_r <= 1'b1;
    end
  end

endmodule

// File: rtl/adi_dma_split_logic.sv
// -----------------------------------------------------------------------------
// adi_dma_split_logic
// Splits one long AXI-Stream frame into num_pkts packets of pkt_len beats,
// inserting M_AXIS_TLAST on each packet boundary.
// Ports:
//   AXIS_ACLK, AXIS_ARESET   clock, synchronous active-high reset
//   S_AXIS_*                 input frame
//   M_AXIS_*                 output packets
//   cmd                      [0] en, [1] soft reset, [2] passthrough
//   status                   [0] done, [1] err_short, [2] err_long,
//                            [3] err_cfg, [31:16] packets sent (saturating)
//   num_pkts, pkt_len        frame geometry, latched on start
// TLAST is computed on the input side and stored with the beat, so the
// boundary compares only ever see registered flags (pkt_end_r/last_pkt_r).
// -----------------------------------------------------------------------------
module adi_dma_split_logic
  import adi_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESET,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  input  logic [31:0]           cmd,
  output logic [31:0]           status,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  input  logic [CNT_WIDTH-1:0]  pkt_len
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_TWO  = {{(CNT_WIDTH-2){1'b0}}, 2'b10};

  dma_state_e             state_r, state_n, fin_tgt_r, fin_tgt_s;
  logic                   en_r, pass_r, fin_r, done_r;
  logic                   err_short_r, err_long_r, err_cfg_r;
  logic [CNT_WIDTH-1:0]   num_r, len_r, beat_cnt_r, pkt_cnt_r;
  logic                   pkt_end_r, last_pkt_r;
  logic [15:0]            sent_r;
  logic                   rst_s, buf_empty_s, buf_rdy_s, buf_valid_s;
  logic                   run_fwd_s, drain_s, fwd_s, s_xfr_s, run_xfr_s, tag_last_s;
  logic                   start_s, cfg_bad_s, fin_set_s, set_short_s, set_long_s;
  logic [DATA_WIDTH:0]    m_payload_s;
  logic [28:0]            cmd_unused_s;

  assign cmd_unused_s = cmd[31:3];
  assign rst_s        = AXIS_ARESET | cmd[CMD_RST];

  // Accept windows are built from registers only (en_r rather than cmd[0]).
  assign run_fwd_s     = (state_r == ST_RUN) & en_r & ~fin_r & ~pass_r;
  assign drain_s       = (state_r == ST_DRAIN) & ~pass_r;
  assign fwd_s         = pass_r | run_fwd_s;
  assign S_AXIS_TREADY = (fwd_s & buf_rdy_s) | drain_s;
  assign s_xfr_s       = S_AXIS_TVALID & S_AXIS_TREADY;
  assign run_xfr_s     = s_xfr_s & run_fwd_s;
  assign tag_last_s    = pass_r ? S_AXIS_TLAST : (pkt_end_r | S_AXIS_TLAST);
  assign buf_valid_s   = S_AXIS_TVALID & fwd_s;

  adi_axis_skid_buf #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clk     (AXIS_ACLK),
    .srst    (rst_s),
    .s_valid (buf_valid_s),
    .s_ready (buf_rdy_s),
    .s_data  ({tag_last_s, S_AXIS_TDATA}),
    .m_valid (M_AXIS_TVALID),
    .m_ready (M_AXIS_TREADY),
    .m_data  (m_payload_s),
    .empty   (buf_empty_s)
  );

  assign M_AXIS_TDATA = m_payload_s[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST = m_payload_s[DATA_WIDTH];

  // Status word assembled from registered flags.
  always_comb begin
    status                             = 32'h0000_0000;
    status[STAT_DONE]                  = done_r;
    status[STAT_ERR_SHORT]             = err_short_r;
    status[STAT_ERR_LONG]              = err_long_r;
    status[STAT_ERR_CFG]               = err_cfg_r;
    status[STAT_CNT_MSB:STAT_CNT_LSB]  = sent_r;
  end

  // Next-state logic. After the final beat of a frame is accepted the FSM
  // waits in RUN (fin_r) until the slice is empty, so DONE/DRAIN never
  // coexist with buffered output.
  always_comb begin
    state_n     = state_r;
    fin_tgt_s   = fin_tgt_r;
    start_s     = 1'b0;
    cfg_bad_s   = 1'b0;
    fin_set_s   = 1'b0;
    set_short_s = 1'b0;
    set_long_s  = 1'b0;
    if (pass_r) begin
      state_n = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd[CMD_EN]) begin
            start_s = 1'b1;
            if ((num_pkts == CNT_ZERO) || (pkt_len == CNT_ZERO)) begin
              cfg_bad_s = 1'b1;
              state_n   = ST_DONE;
            end else begin
              state_n = ST_RUN;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (fin_r) begin
            if (buf_empty_s) begin
              state_n = fin_tgt_r;
            end else begin
              state_n = ST_RUN;
            end
          end else if (run_xfr_s) begin
            if (pkt_end_r & last_pkt_r) begin
              fin_set_s = 1'b1;
              if (S_AXIS_TLAST) begin
                fin_tgt_s = ST_DONE;
              end else begin
                fin_tgt_s  = ST_DRAIN;
                set_long_s = 1'b1;
              end
            end else if (S_AXIS_TLAST) begin
              fin_set_s   = 1'b1;
              fin_tgt_s   = ST_DONE;
              set_short_s = 1'b1;
            end else begin
              fin_set_s = 1'b0;
            end
          end else begin
            state_n = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (s_xfr_s & S_AXIS_TLAST) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (!cmd[CMD_EN]) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DONE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge AXIS_ACLK) begin
    if (rst_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Counters, boundary flags, error flags and mode registers.
  always_ff @(posedge AXIS_ACLK) begin
    if (rst_s) begin
      en_r        <= 1'b0;
      pass_r      <= 1'b0;
      done_r      <= 1'b0;
      fin_r       <= 1'b0;
      fin_tgt_r   <= ST_IDLE;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      err_cfg_r   <= 1'b0;
      num_r       <= CNT_ZERO;
      len_r       <= CNT_ZERO;
      beat_cnt_r  <= CNT_ZERO;
      pkt_cnt_r   <= CNT_ZERO;
      pkt_end_r   <= 1'b0;
      last_pkt_r  <= 1'b0;
      sent_r      <= 16'h0000;
    end else begin
      en_r   <= cmd[CMD_EN];
      done_r <= (state_n == ST_DONE);
      // Mode switches only at an empty slice so no beat changes meaning mid-flight.
      if (buf_empty_s) begin
        pass_r <= cmd[CMD_PASS];
      end
      if (start_s) begin
        num_r       <= num_pkts;
        len_r       <= pkt_len;
        beat_cnt_r  <= CNT_ZERO;
        pkt_cnt_r   <= CNT_ZERO;
        pkt_end_r   <= (pkt_len == CNT_ONE);
        last_pkt_r  <= (num_pkts == CNT_ONE);
        err_short_r <= 1'b0;
        err_long_r  <= 1'b0;
        err_cfg_r   <= cfg_bad_s;
        sent_r      <= 16'h0000;
        fin_r       <= 1'b0;
      end else begin
        if (set_short_s) begin
          err_short_r <= 1'b1;
        end
        if (set_long_s) begin
          err_long_r <= 1'b1;
        end
        if (fin_set_s) begin
          fin_r     <= 1'b1;
          fin_tgt_r <= fin_tgt_s;
        end else if (fin_r && (state_n != ST_RUN)) begin
          fin_r <= 1'b0;
        end
        // Flags look one beat ahead so TLAST needs no compare on the data path.
        if (run_xfr_s) begin
          if (tag_last_s) begin
            beat_cnt_r <= CNT_ZERO;
            pkt_cnt_r  <= pkt_cnt_r + CNT_ONE;
            sent_r     <= sat_inc16(sent_r);
            pkt_end_r  <= (len_r == CNT_ONE);
            last_pkt_r <= ((pkt_cnt_r + CNT_TWO) == num_r);
          end else begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
            pkt_end_r  <= ((beat_cnt_r + CNT_TWO) == len_r);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adi_dma_split_logic.sv
// Self-checking bench for adi_dma_split_logic: table of frame configurations
// plus hand-written sequences for config error, soft reset and passthrough.
module tb_adi_dma_split_logic;

  logic        AXIS_ACLK;
  logic        AXIS_ARESET;
  logic        S_AXIS_TREADY;
  logic [63:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic [31:0] cmd;
  logic [31:0] status;
  logic [31:0] num_pkts;
  logic [31:0] pkt_len;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    int          nbeats;
    int          npk;
    int          plen;
    bit          rnd;
    logic [31:0] exp_status;
  } vec_t;

  beat_t sb_q[$];
  vec_t  vecs[7];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    s_xfr_cnt = 0;
  bit    rnd_rdy  = 1'b0;
  bit    hold_chk = 1'b0;
  bit    s_acc    = 1'b0;
  beat_t hold_beat;

  adi_dma_split_logic #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .AXIS_ACLK     (AXIS_ACLK),
    .AXIS_ARESET   (AXIS_ARESET),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .cmd           (cmd),
    .status        (status),
    .num_pkts      (num_pkts),
    .pkt_len       (pkt_len)
  );

  initial AXIS_ACLK = 1'b0;
  always #5 AXIS_ACLK = ~AXIS_ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample/score outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    beat_t e;
    @(negedge AXIS_ACLK);
    if (hold_chk) begin
      chk("stall_valid", 64'(M_AXIS_TVALID), 64'd1);
      chk("stall_data", M_AXIS_TDATA, hold_beat.data);
      chk("stall_last", 64'(M_AXIS_TLAST), 64'(hold_beat.last));
    end
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h last %0b with no beat expected", M_AXIS_TDATA, M_AXIS_TLAST);
      end else begin
        e = sb_q.pop_front();
        chk("m_data", M_AXIS_TDATA, e.data);
        chk("m_last", 64'(M_AXIS_TLAST), 64'(e.last));
      end
    end
    hold_chk  = M_AXIS_TVALID && !M_AXIS_TREADY;
    hold_beat = {M_AXIS_TLAST, M_AXIS_TDATA};
    s_acc     = S_AXIS_TVALID && S_AXIS_TREADY;
    if (s_acc) s_xfr_cnt++;
    @(posedge AXIS_ACLK);
    #1;
    if (rnd_rdy) M_AXIS_TREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int t;
    t = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    s_acc = 1'b0;
    while (!s_acc && t < 300) begin
      tick();
      t++;
    end
    chk("s_accept", 64'(s_acc), 64'd1);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    logic [63:0] d;
    logic        l;
    int          t;
    num_pkts = 32'(v.npk);
    pkt_len  = 32'(v.plen);
    rnd_rdy  = v.rnd;
    M_AXIS_TREADY = 1'b1;
    cmd = 32'h0000_0001;
    for (int i = 0; i < v.nbeats; i++) begin
      d = {$urandom, 32'(i)};
      l = (i == v.nbeats - 1);
      if (i < v.npk * v.plen) sb_q.push_back({((i % v.plen) == (v.plen - 1)) || l, d});
      send_beat(d, l);
    end
    t = 0;
    while (!status[0] && t < 500) begin
      tick();
      t++;
    end
    chk("status", 64'(status), 64'(v.exp_status));
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    rnd_rdy = 1'b0;
    M_AXIS_TREADY = 1'b1;
    cmd = 32'h0000_0000;
    tick();
    tick();
  endtask

  initial begin
    int          t;
    logic [63:0] d;

    vecs[0] = '{nbeats: 12, npk: 3, plen: 4, rnd: 1'b0, exp_status: 32'h0003_0001};
    vecs[1] = '{nbeats: 12, npk: 3, plen: 4, rnd: 1'b1, exp_status: 32'h0003_0001};
    vecs[2] = '{nbeats: 10, npk: 3, plen: 4, rnd: 1'b0, exp_status: 32'h0003_0003};
    vecs[3] = '{nbeats: 15, npk: 3, plen: 4, rnd: 1'b0, exp_status: 32'h0003_0005};
    vecs[4] = '{nbeats: 5,  npk: 5, plen: 1, rnd: 1'b0, exp_status: 32'h0005_0001};
    vecs[5] = '{nbeats: 7,  npk: 1, plen: 7, rnd: 1'b0, exp_status: 32'h0001_0001};
    vecs[6] = '{nbeats: 6,  npk: 2, plen: 4, rnd: 1'b1, exp_status: 32'h0002_0003};

    AXIS_ARESET   = 1'b1;
    S_AXIS_TDATA  = 64'h0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;
    cmd           = 32'h0;
    num_pkts      = 32'd3;
    pkt_len       = 32'd4;
    repeat (3) tick();
    chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
    chk("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_m_tlast", 64'(M_AXIS_TLAST), 64'd0);
    chk("rst_m_tdata", M_AXIS_TDATA, 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    AXIS_ARESET = 1'b0;
    tick();
    chk("idle_s_tready", 64'(S_AXIS_TREADY), 64'd0);

    for (int k = 0; k < 7; k++) run_case(vecs[k]);

    // Zero packet length: straight to DONE with err_cfg, nothing accepted.
    num_pkts = 32'd3;
    pkt_len  = 32'd0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 64'hDEAD_BEEF_0000_0001;
    s_xfr_cnt = 0;
    cmd = 32'h0000_0001;
    tick();
    chk("cfg_status", 64'(status), 64'h0000_0009);
    tick();
    tick();
    chk("cfg_no_accept", 64'(s_xfr_cnt), 64'd0);
    chk("cfg_no_valid", 64'(M_AXIS_TVALID), 64'd0);
    S_AXIS_TVALID = 1'b0;
    cmd = 32'h0;
    tick();
    tick();

    // Soft reset with beat 6 of a 3x4 frame still held in the slice.
    num_pkts = 32'd3;
    pkt_len  = 32'd4;
    M_AXIS_TREADY = 1'b1;
    cmd = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, 32'(i)};
      sb_q.push_back({i == 3, d});
      send_beat(d, 1'b0);
    end
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk("srst_pre_drained", 64'(sb_q.size()), 64'd0);
    M_AXIS_TREADY = 1'b0;
    send_beat(64'h0BAD_0BAD_0000_0005, 1'b0);
    tick();
    chk("srst_pending_valid", 64'(M_AXIS_TVALID), 64'd1);
    cmd = 32'h0000_0002;
    tick();
    hold_chk = 1'b0;
    cmd = 32'h0;
    chk("srst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("srst_m_tlast", 64'(M_AXIS_TLAST), 64'd0);
    chk("srst_m_tdata", M_AXIS_TDATA, 64'd0);
    chk("srst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
    chk("srst_status", 64'(status), 64'd0);
    M_AXIS_TREADY = 1'b1;
    tick();
    run_case(vecs[0]);

    // Passthrough: 5-beat frame, one TLAST on beat 5, state and counters frozen.
    cmd = 32'h0000_0004;
    tick();
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, 32'(i + 100)};
      sb_q.push_back({i == 4, d});
      send_beat(d, i == 4);
    end
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk("pass_drained", 64'(sb_q.size()), 64'd0);
    chk("pass_status", 64'(status), 64'h0003_0000);
    cmd = 32'h0;
    tick();
    tick();
    chk("pass_off_tready", 64'(S_AXIS_TREADY), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
